// File: rtl/rx_frame_if.sv
// Byte-stream and host-side bundle for rx_frame_module.
// slave: the parser; master: byte source plus host reader.
interface rx_frame_if #(
   parameter int MAX_LEN = 16
);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic          rx_done_sig;
   logic [7:0]    rx_data;
   logic          rx_en_sig;
   logic          frame_valid;
   logic [7:0]    frame_len;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          frame_ack;
   logic          frame_err_sig;
   logic [1:0]    err_code;

   modport slave (
      input  rx_done_sig, rx_data, rd_addr, frame_ack,
      output rx_en_sig, frame_valid, frame_len,
      output rd_data, frame_err_sig, err_code
   );

   modport master (
      output rx_done_sig, rx_data, rd_addr, frame_ack,
      input  rx_en_sig, frame_valid, frame_len,
      input  rd_data, frame_err_sig, err_code
   );
endinterface

// File: rtl/rx_frame_module.sv
// Header-hunting, length-prefixed, checksummed frame parser.
// Ports: clk, rst_n (async low), bus (rx_frame_if.slave).
module rx_frame_module #(
   parameter int MAX_LEN      = 16,
   parameter int TIMEOUT_CLKS = 156250
) (
   input  logic     clk,
   input  logic     rst_n,
   rx_frame_if.slave bus
);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {
      S_HDR0, S_HDR1, S_LEN, S_DATA, S_CHK, S_HOLD
   } state_t;

   state_t      state, state_d;
   logic [7:0]  len_q, chk_q, cnt_q, len_out_q;
   logic [31:0] tmo_q;
   logic        in_frame, tmo_hit, done;
   logic        err_d, err_q, en_q;
   logic [1:0]  code_d, code_q;
   logic [7:0]  rd_q;
   logic [7:0]  mem [MAX_LEN];
   logic [AW-1:0] addr;

   assign done = bus.rx_done_sig;
   assign addr = bus.rd_addr;

   assign in_frame = (state == S_HDR1) || (state == S_LEN) ||
                     (state == S_DATA) || (state == S_CHK);
   // fire on the edge where the idle count would reach its limit
   assign tmo_hit = in_frame && !done && (tmo_q + 32'd1 >= TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_HDR0;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      err_d   = 1'b0;
      code_d  = 2'd0;
      if (tmo_hit) begin
         state_d = S_HDR0;
         err_d   = 1'b1;
         code_d  = 2'd3;
      end else begin
         unique case (state)
            S_HDR0: if (done && bus.rx_data == 8'h55) state_d = S_HDR1;
            S_HDR1: if (done) begin
               if (bus.rx_data == 8'hAA)      state_d = S_LEN;
               else if (bus.rx_data != 8'h55) state_d = S_HDR0;
            end
            S_LEN: if (done) begin
               if (bus.rx_data == 8'd0 ||
                   32'(bus.rx_data) > MAX_LEN) begin
                  state_d = S_HDR0;
                  err_d   = 1'b1;
                  code_d  = 2'd1;
               end else begin
                  state_d = S_DATA;
               end
            end
            S_DATA: if (done && cnt_q == len_q - 8'd1) state_d = S_CHK;
            S_CHK: if (done) begin
               if (bus.rx_data == chk_q) begin
                  state_d = S_HOLD;
               end else begin
                  state_d = S_HDR0;
                  err_d   = 1'b1;
                  code_d  = 2'd2;
               end
            end
            S_HOLD: begin
               if (bus.frame_ack) state_d = S_HDR0;
               if (done) begin
                  err_d  = 1'b1;
                  code_d = 2'd0;
               end
            end
            default: state_d = S_HDR0;
         endcase
      end
   end

   always_comb begin
      bus.frame_valid   = (state == S_HOLD);
      bus.rx_en_sig     = en_q;
      bus.frame_len     = len_out_q;
      bus.rd_data       = rd_q;
      bus.frame_err_sig = err_q;
      bus.err_code      = code_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q     <= 8'd0;
         chk_q     <= 8'd0;
         cnt_q     <= 8'd0;
         len_out_q <= 8'd0;
         tmo_q     <= 32'd0;
         err_q     <= 1'b0;
         code_q    <= 2'd0;
         en_q      <= 1'b0;
         rd_q      <= 8'd0;
      end else begin
         err_q <= err_d;
         if (err_d) code_q <= code_d;
         en_q <= (state_d != S_HOLD);
         if (!in_frame || done || tmo_hit) tmo_q <= 32'd0;
         else                              tmo_q <= tmo_q + 32'd1;
         if (done && !tmo_hit) begin
            if (state == S_LEN) begin
               len_q <= bus.rx_data;
               chk_q <= bus.rx_data;
               cnt_q <= 8'd0;
            end
            if (state == S_DATA) begin
               chk_q <= chk_q + bus.rx_data;
               cnt_q <= cnt_q + 8'd1;
            end
            if (state == S_CHK && bus.rx_data == chk_q)
               len_out_q <= len_q;
         end
         rd_q <= (32'(addr) < MAX_LEN) ? mem[addr] : 8'h00;
      end
   end

   // payload storage has no reset; bytes beyond len are stale
   always_ff @(posedge clk) begin
      if (state == S_DATA && done)
         mem[cnt_q[AW-1:0]] <= bus.rx_data;
   end
endmodule

// File: tb/tb_rx_frame_module.sv
// Directed bench for rx_frame_module.
// Hand-computed frames, errors, timeout, hold and reset cases.
module tb_rx_frame_module;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   int   n;

   rx_frame_if #(.MAX_LEN(16)) bus ();

   rx_frame_module #(
      .MAX_LEN(16),
      .TIMEOUT_CLKS(100)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_done_sig = 1'b1;
      bus.rx_data     = b;
      tick();
      bus.rx_done_sig = 1'b0;
   endtask

   task automatic read(input logic [3:0] a, input logic [7:0] exp,
                       input string tag);
      bus.rd_addr = a;
      tick();
      check(tag, 32'(bus.rd_data), 32'(exp));
   endtask

   task automatic ack();
      bus.frame_ack = 1'b1;
      tick();
      bus.frame_ack = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      bus.rx_done_sig = 1'b0;
      bus.rx_data = 8'h00;
      bus.rd_addr = '0;
      bus.frame_ack = 1'b0;
      tick();
      tick();
      check("rst_en", 32'(bus.rx_en_sig), 0);
      check("rst_valid", 32'(bus.frame_valid), 0);
      check("rst_len", 32'(bus.frame_len), 0);
      check("rst_rd", 32'(bus.rd_data), 0);
      check("rst_err", 32'(bus.frame_err_sig), 0);
      check("rst_code", 32'(bus.err_code), 0);
      rst_n = 1'b1;
      tick();
      check("en_up", 32'(bus.rx_en_sig), 1);

      // good frame
      send(8'h55); send(8'hAA); send(8'h03);
      send(8'h11); send(8'h22); send(8'h33);
      check("pre_valid", 32'(bus.frame_valid), 0);
      send(8'h69);
      check("t1_valid", 32'(bus.frame_valid), 1);
      check("t1_len", 32'(bus.frame_len), 3);
      check("t1_en", 32'(bus.rx_en_sig), 0);
      check("t1_err", 32'(bus.frame_err_sig), 0);
      read(4'd0, 8'h11, "t1_rd0");
      read(4'd1, 8'h22, "t1_rd1");
      read(4'd2, 8'h33, "t1_rd2");
      ack();
      check("t1_ack_valid", 32'(bus.frame_valid), 0);
      check("t1_ack_en", 32'(bus.rx_en_sig), 1);

      // checksum error then recovery
      send(8'h55); send(8'hAA); send(8'h03);
      send(8'h11); send(8'h22); send(8'h33);
      send(8'h68);
      check("t2_err", 32'(bus.frame_err_sig), 1);
      check("t2_code", 32'(bus.err_code), 2);
      check("t2_valid", 32'(bus.frame_valid), 0);
      tick();
      check("t2_pulse", 32'(bus.frame_err_sig), 0);
      send(8'h55); send(8'hAA); send(8'h01);
      send(8'h05); send(8'h06);
      check("t2_ok", 32'(bus.frame_valid), 1);
      check("t2_len", 32'(bus.frame_len), 1);
      ack();

      // length errors
      send(8'h55); send(8'hAA); send(8'h00);
      check("t3_err0", 32'(bus.frame_err_sig), 1);
      check("t3_code0", 32'(bus.err_code), 1);
      send(8'h55); send(8'hAA); send(8'h11);
      check("t3_err17", 32'(bus.frame_err_sig), 1);
      check("t3_code17", 32'(bus.err_code), 1);
      send(8'h12); send(8'h55); send(8'hAA); send(8'h01);
      send(8'hFF); send(8'h00);
      check("t3_valid", 32'(bus.frame_valid), 1);
      check("t3_len", 32'(bus.frame_len), 1);
      read(4'd0, 8'hFF, "t3_rd0");
      ack();

      // timeout after the last payload byte
      send(8'h55); send(8'hAA); send(8'h02); send(8'h10);
      n = 0;
      while (!bus.frame_err_sig && n < 200) begin
         tick();
         n++;
      end
      check("t4_delay", 32'(n), 99);
      check("t4_code", 32'(bus.err_code), 3);
      send(8'h55); send(8'h55); send(8'hAA); send(8'h01);
      send(8'h05); send(8'h06);
      check("t4_valid", 32'(bus.frame_valid), 1);
      read(4'd0, 8'h05, "t4_rd0");

      // bytes arriving while a frame is held
      send(8'h77);
      check("t5_err", 32'(bus.frame_err_sig), 1);
      check("t5_code", 32'(bus.err_code), 0);
      check("t5_valid", 32'(bus.frame_valid), 1);
      read(4'd0, 8'h05, "t5_rd0");
      read(4'd1, 8'h22, "t5_rd1");
      bus.frame_ack = 1'b1;
      send(8'h55);
      bus.frame_ack = 1'b0;
      check("t5_ack_err", 32'(bus.frame_err_sig), 1);
      check("t5_ack_code", 32'(bus.err_code), 0);
      check("t5_ack_valid", 32'(bus.frame_valid), 0);
      check("t5_ack_en", 32'(bus.rx_en_sig), 1);
      send(8'h55); send(8'hAA); send(8'h01);
      send(8'h07); send(8'h08);
      check("t5_next", 32'(bus.frame_valid), 1);
      read(4'd0, 8'h07, "t5_rd_next");
      ack();

      // reset mid-payload
      send(8'h55); send(8'hAA); send(8'h03); send(8'h11);
      rst_n = 1'b0;
      #2;
      check("t6_en", 32'(bus.rx_en_sig), 0);
      check("t6_valid", 32'(bus.frame_valid), 0);
      check("t6_len", 32'(bus.frame_len), 0);
      check("t6_rd", 32'(bus.rd_data), 0);
      check("t6_code", 32'(bus.err_code), 0);
      tick();
      check("t6_err", 32'(bus.frame_err_sig), 0);
      rst_n = 1'b1;
      tick();
      check("t6_en_up", 32'(bus.rx_en_sig), 1);
      send(8'h55); send(8'hAA); send(8'h02);
      send(8'h01); send(8'h02); send(8'h05);
      check("t6_valid2", 32'(bus.frame_valid), 1);
      check("t6_len2", 32'(bus.frame_len), 2);
      read(4'd1, 8'h02, "t6_rd1");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
